decode_issue: RTL and testbench

Decode/issue stage of the five-stage MIPS core. It takes the fetched instruction, drives the register file read addresses, and resolves operands by forwarding from the EX/MEM/WB results. It detects load-use hazards and stalls, and holds the result in the D/E pipeline register consumed by the execute stage.

---
 rtl/decode_issue_pkg.sv | 17 +
 rtl/decode_issue_fwd_mux.sv | 37 +++
 rtl/decode_issue.sv | 93 +++++++++
 tb/tb_decode_issue.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/decode_issue_pkg.sv
// Shared types for the decode/issue slice: machine word, register index and
// the bypass bundle each later pipeline stage presents back to decode.
package decode_issue_pkg;

  typedef logic [31:0] word_t;
  typedef logic [4:0]  regidx_t;

  typedef struct packed {
    logic    valid;
    logic    we;
    regidx_t wa;
    word_t   wd;
  } bypass_t;

  localparam word_t RESET_PC = 32'hBFC0_0000;

endpackage

// File: rtl/decode_issue_fwd_mux.sv
// Operand resolution for one source register: picks the youngest in-flight
// producer, falling back to the regfile, and flags a pending load producer.
module fwd_mux
  import decode_issue_pkg::*;
(
  input  regidx_t idx,
  input  word_t   rf_data,
  input  bypass_t ex_byp,
  input  bypass_t mem_byp,
  input  bypass_t wb_byp,
  input  logic    ex_is_load,
  output word_t   value,
  output logic    load_hit
);

  logic ex_hit;
  logic mem_hit;
  logic wb_hit;
  logic idx_nz;

  assign idx_nz  = (idx != 5'd0);
  assign ex_hit  = ex_byp.valid  & ex_byp.we  & (ex_byp.wa  == idx) & idx_nz;
  assign mem_hit = mem_byp.valid & mem_byp.we & (mem_byp.wa == idx) & idx_nz;
  assign wb_hit  = wb_byp.valid  & wb_byp.we  & (wb_byp.wa  == idx) & idx_nz;

  assign load_hit = ex_hit & ex_is_load;

  // WB must forward: the regfile read returns the value before this cycle's write.
  always_comb begin
    value = rf_data;
    if (!idx_nz)                   value = '0;
    else if (ex_hit && !ex_is_load) value = ex_byp.wd;
    else if (mem_hit)              value = mem_byp.wd;
    else if (wb_hit)               value = wb_byp.wd;
  end

endmodule

// File: rtl/decode_issue.sv
// Decode/issue stage: drives regfile read addresses, forwards operands,
// stalls on load-use hazards and holds the D/E pipeline register.
module decode_issue
  import decode_issue_pkg::*;
(
  input  logic        clk,
  input  logic        resetn,
  input  logic        in_valid,
  input  logic [31:0] in_pc,
  input  logic [31:0] in_instr,
  output logic        in_ready,
  output logic [4:0]  ra1,
  output logic [4:0]  ra2,
  input  logic [31:0] rd1,
  input  logic [31:0] rd2,
  input  bypass_t     ex_byp,
  input  bypass_t     mem_byp,
  input  bypass_t     wb_byp,
  input  logic        ex_is_load,
  input  logic        flush,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_pc,
  output logic [31:0] out_instr,
  output logic [31:0] out_rs_val,
  output logic [31:0] out_rt_val,
  output logic [31:0] stall_cnt
);

  // Handshakes: a transfer happens on a clock edge where valid & ready are both
  // high; valid never depends on ready, and the sender holds its payload until
  // the transfer completes.

  word_t rs_val;
  word_t rt_val;
  logic  rs_load_hit;
  logic  rt_load_hit;
  logic  hazard;
  logic  advance;

  assign ra1 = in_instr[25:21];
  assign ra2 = in_instr[20:16];

  fwd_mux u_fwd_rs (
    .idx        (ra1),
    .rf_data    (rd1),
    .ex_byp     (ex_byp),
    .mem_byp    (mem_byp),
    .wb_byp     (wb_byp),
    .ex_is_load (ex_is_load),
    .value      (rs_val),
    .load_hit   (rs_load_hit)
  );

  fwd_mux u_fwd_rt (
    .idx        (ra2),
    .rf_data    (rd2),
    .ex_byp     (ex_byp),
    .mem_byp    (mem_byp),
    .wb_byp     (wb_byp),
    .ex_is_load (ex_is_load),
    .value      (rt_val),
    .load_hit   (rt_load_hit)
  );

  // Both sources are treated as used for every instruction.
  assign hazard   = in_valid & (rs_load_hit | rt_load_hit);
  assign advance  = ~out_valid | out_ready;
  assign in_ready = advance & ~hazard & ~flush;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      out_valid  <= 1'b0;
      out_pc     <= RESET_PC;
      out_instr  <= '0;
      out_rs_val <= '0;
      out_rt_val <= '0;
      stall_cnt  <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (advance && hazard) begin
      out_valid <= 1'b0;
      if (stall_cnt != 32'hFFFF_FFFF) stall_cnt <= stall_cnt + 32'd1;
    end else if (advance) begin
      out_valid  <= in_valid;
      out_pc     <= in_pc;
      out_instr  <= in_instr;
      out_rs_val <= rs_val;
      out_rt_val <= rt_val;
    end
  end

endmodule

// File: tb/tb_decode_issue.sv
// Directed bench for decode_issue: issue, forwarding priority, $0 guard,
// load-use stall, backpressure, flush and reset during a stall.
module tb_decode_issue;
  import decode_issue_pkg::*;

  logic        clk;
  logic        resetn;
  logic        in_valid;
  logic [31:0] in_pc;
  logic [31:0] in_instr;
  logic        in_ready;
  logic [4:0]  ra1;
  logic [4:0]  ra2;
  logic [31:0] rd1;
  logic [31:0] rd2;
  bypass_t     ex_byp;
  bypass_t     mem_byp;
  bypass_t     wb_byp;
  logic        ex_is_load;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_instr;
  logic [31:0] out_rs_val;
  logic [31:0] out_rt_val;
  logic [31:0] stall_cnt;

  int checks = 0;
  int errors = 0;

  decode_issue dut (
    .clk        (clk),
    .resetn     (resetn),
    .in_valid   (in_valid),
    .in_pc      (in_pc),
    .in_instr   (in_instr),
    .in_ready   (in_ready),
    .ra1        (ra1),
    .ra2        (ra2),
    .rd1        (rd1),
    .rd2        (rd2),
    .ex_byp     (ex_byp),
    .mem_byp    (mem_byp),
    .wb_byp     (wb_byp),
    .ex_is_load (ex_is_load),
    .flush      (flush),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_pc     (out_pc),
    .out_instr  (out_instr),
    .out_rs_val (out_rs_val),
    .out_rt_val (out_rt_val),
    .stall_cnt  (stall_cnt)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic bypass_t mk_byp(logic v, logic we, logic [4:0] wa, logic [31:0] wd);
    mk_byp = {v, we, wa, wd};
  endfunction

  // encode R-type addu rd, rs, rt
  function automatic logic [31:0] addu(logic [4:0] rd, logic [4:0] rs, logic [4:0] rt);
    addu = {6'd0, rs, rt, rd, 5'd0, 6'h21};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  logic [31:0] held_pc;
  logic [31:0] held_instr;

  initial begin
    resetn     = 1'b0;
    in_valid   = 1'b0;
    in_pc      = '0;
    in_instr   = '0;
    rd1        = '0;
    rd2        = '0;
    ex_byp     = '0;
    mem_byp    = '0;
    wb_byp     = '0;
    ex_is_load = 1'b0;
    flush      = 1'b0;
    out_ready  = 1'b1;
    tick();
    tick();
    resetn = 1'b1;

    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_out_pc", out_pc, 32'hBFC0_0000);
    check("rst_out_instr", out_instr, 32'd0);
    check("rst_stall_cnt", stall_cnt, 32'd0);

    // plain issue: addu $3,$1,$2
    in_valid = 1'b1;
    in_pc    = 32'h0000_0100;
    in_instr = addu(5'd3, 5'd1, 5'd2);
    rd1      = 32'd5;
    rd2      = 32'd7;
    #1;
    check("plain_ra1", {27'd0, ra1}, 32'd1);
    check("plain_ra2", {27'd0, ra2}, 32'd2);
    check("plain_in_ready", {31'd0, in_ready}, 32'd1);
    tick();
    check("plain_out_valid", {31'd0, out_valid}, 32'd1);
    check("plain_rs", out_rs_val, 32'd5);
    check("plain_rt", out_rt_val, 32'd7);
    check("plain_pc", out_pc, 32'h0000_0100);
    check("plain_instr", out_instr, 32'h0022_1821);

    // forwarding priority on rs=$4
    in_pc    = 32'h0000_0104;
    in_instr = addu(5'd6, 5'd4, 5'd7);
    rd1      = 32'h99;
    rd2      = 32'h77;
    ex_byp   = mk_byp(1'b1, 1'b1, 5'd4, 32'h11);
    mem_byp  = mk_byp(1'b1, 1'b1, 5'd4, 32'h22);
    wb_byp   = mk_byp(1'b1, 1'b1, 5'd4, 32'h33);
    tick();
    check("fwd_ex", out_rs_val, 32'h11);
    check("fwd_ex_rt_rf", out_rt_val, 32'h77);
    ex_byp.valid = 1'b0;
    tick();
    check("fwd_mem", out_rs_val, 32'h22);
    mem_byp.valid = 1'b0;
    tick();
    check("fwd_wb", out_rs_val, 32'h33);
    wb_byp.we = 1'b0;
    tick();
    check("fwd_none_rf", out_rs_val, 32'h99);
    wb_byp = '0;

    // $0 guard
    in_pc    = 32'h0000_0110;
    in_instr = addu(5'd6, 5'd0, 5'd7);
    rd1      = 32'h1234;
    ex_byp   = mk_byp(1'b1, 1'b1, 5'd0, 32'hFFFF_FFFF);
    tick();
    check("zero_guard", out_rs_val, 32'd0);

    // load-use on rt=$5
    in_pc      = 32'h0000_0140;
    in_instr   = addu(5'd6, 5'd1, 5'd5);
    rd1        = 32'd1;
    rd2        = 32'd0;
    ex_byp     = mk_byp(1'b1, 1'b1, 5'd5, 32'hDEAD);
    ex_is_load = 1'b1;
    #1;
    check("lu_ra2", {27'd0, ra2}, 32'd5);
    check("lu_in_ready", {31'd0, in_ready}, 32'd0);
    tick();
    check("lu_bubble", {31'd0, out_valid}, 32'd0);
    check("lu_stall_cnt", stall_cnt, 32'd1);
    ex_byp     = '0;
    ex_is_load = 1'b0;
    mem_byp    = mk_byp(1'b1, 1'b1, 5'd5, 32'hABCD);
    #1;
    check("lu_retry_ready", {31'd0, in_ready}, 32'd1);
    tick();
    check("lu_accept_valid", {31'd0, out_valid}, 32'd1);
    check("lu_accept_rt", out_rt_val, 32'hABCD);
    check("lu_stall_keep", stall_cnt, 32'd1);
    held_pc    = out_pc;
    held_instr = out_instr;
    check("lu_pc", held_pc, 32'h0000_0140);

    // backpressure, with a load-use hazard in the last cycle
    out_ready = 1'b0;
    mem_byp   = '0;
    in_pc     = 32'h0000_0200;
    in_instr  = addu(5'd9, 5'd5, 5'd8);
    rd1       = 32'h5555;
    rd2       = 32'h8888;
    for (int i = 0; i < 3; i++) begin
      if (i == 2) begin
        ex_byp     = mk_byp(1'b1, 1'b1, 5'd5, 32'h0);
        ex_is_load = 1'b1;
      end
      #1;
      check("bp_in_ready", {31'd0, in_ready}, 32'd0);
      tick();
      check("bp_valid", {31'd0, out_valid}, 32'd1);
      check("bp_pc", out_pc, held_pc);
      check("bp_instr", out_instr, held_instr);
      check("bp_rt", out_rt_val, 32'hABCD);
      check("bp_stall_cnt", stall_cnt, 32'd1);
    end

    // flush with hazard still present
    out_ready = 1'b1;
    flush     = 1'b1;
    #1;
    check("fl_in_ready", {31'd0, in_ready}, 32'd0);
    tick();
    check("fl_out_valid", {31'd0, out_valid}, 32'd0);
    check("fl_stall_cnt", stall_cnt, 32'd1);
    flush = 1'b0;
    tick();
    check("fl_then_stall", stall_cnt, 32'd2);
    check("fl_then_bubble", {31'd0, out_valid}, 32'd0);

    // reset mid-stall
    resetn = 1'b0;
    tick();
    check("rst2_pc", out_pc, 32'hBFC0_0000);
    check("rst2_stall_cnt", stall_cnt, 32'd0);
    check("rst2_valid", {31'd0, out_valid}, 32'd0);
    check("rst2_rs", out_rs_val, 32'd0);
    resetn = 1'b1;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: observed no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
